// File: rtl/aclk_pkg.sv
// Shared BCD time types, channel state encoding and minute arithmetic
// for the multi-alarm real-time clock.
package aclk_pkg;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_hm_t;

    typedef struct packed {
        bcd_hm_t    hm;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_e;

    localparam int MIN_PER_DAY = 1440;

    function automatic logic bcd_hm_valid(input bcd_hm_t t);
        logic hour_ok;
        hour_ok = (t.h1 < 2'd2) || ((t.h1 == 2'd2) && (t.h0 <= 4'd3));
        return hour_ok && (t.h0 <= 4'd9) && (t.m1 <= 4'd5) && (t.m0 <= 4'd9);
    endfunction

    // Round-trips through minutes-of-day so any n in 0..59 wraps midnight correctly.
    function automatic bcd_hm_t bcd_hm_add_min(input bcd_hm_t t, input logic [5:0] n);
        logic [11:0] total;
        logic [4:0]  hh;
        logic [5:0]  mm;
        bcd_hm_t     r;
        total = 12'(t.h1) * 12'd600 + 12'(t.h0) * 12'd60
              + 12'(t.m1) * 12'd10 + 12'(t.m0) + 12'(n);
        if (total >= 12'(MIN_PER_DAY)) begin
            total = total - 12'(MIN_PER_DAY);
        end
        hh   = 5'(total / 12'd60);
        mm   = 6'(total % 12'd60);
        r.h1 = 2'(hh / 5'd10);
        r.h0 = 4'(hh % 5'd10);
        r.m1 = 4'(mm / 6'd10);
        r.m0 = 4'(mm % 6'd10);
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, IDLE/RINGING/SNOOZED state machine,
// absolute snooze target and minute-based auto-timeout counter.
module alarm_channel
    import aclk_pkg::*;
#(
    parameter int SNOOZE_MIN  = 5,
    parameter int TIMEOUT_MIN = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        al_on,
    input  logic        ld_alarm,
    input  logic [13:0] ld_hm,
    input  logic [13:0] cur_hm,
    input  logic        min_event,
    input  logic        stop_al,
    input  logic        snooze,
    output logic        ringing
);

    localparam logic [5:0] SNOOZE_LEN   = 6'(SNOOZE_MIN);
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT_MIN - 1);

    alarm_state_e state_q, state_d;
    bcd_hm_t      alarm_q, alarm_d;
    bcd_hm_t      target_q, target_d;
    bcd_hm_t      now_hm;
    logic [5:0]   tmo_q, tmo_d;

    assign now_hm = cur_hm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            alarm_q  <= '0;
            target_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            alarm_q  <= alarm_d;
            target_q <= target_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        alarm_d  = alarm_q;
        target_d = target_q;
        tmo_d    = tmo_q;
        if (ld_alarm) begin
            alarm_d = ld_hm;
        end
        if (!al_on || ld_alarm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // A stop in the matching minute suppresses the trigger.
                    if (!stop_al && min_event && (now_hm == alarm_q)) begin
                        state_d = RINGING;
                        tmo_d   = '0;
                    end
                end
                RINGING: begin
                    if (stop_al) begin
                        state_d = IDLE;
                    end else if (snooze) begin
                        state_d  = SNOOZED;
                        target_d = bcd_hm_add_min(now_hm, SNOOZE_LEN);
                    end else if (min_event) begin
                        if (tmo_q == TIMEOUT_LAST) begin
                            state_d = IDLE;
                        end else begin
                            tmo_d = tmo_q + 6'd1;
                        end
                    end
                end
                SNOOZED: begin
                    if (stop_al) begin
                        state_d = IDLE;
                    end else if (min_event && (now_hm == target_q)) begin
                        state_d = RINGING;
                        tmo_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign ringing = (state_q == RINGING);

endmodule

// File: rtl/multi_alarm_clock.sv
// BCD 24-hour real-time clock with a cycle prescaler and NUM_ALARMS
// independent alarm channels sharing a registered minute event.
module multi_alarm_clock
    import aclk_pkg::*;
#(
    parameter int CLK_HZ      = 10,
    parameter int NUM_ALARMS  = 4,
    parameter int SNOOZE_MIN  = 5,
    parameter int TIMEOUT_MIN = 10,
    localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [SEL_W-1:0]      alarm_sel,
    input  logic [NUM_ALARMS-1:0] AL_ON,
    input  logic                  STOP_al,
    input  logic                  SNOOZE,
    output logic                  Alarm,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0
);

    localparam int              PS_W    = $clog2(CLK_HZ);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    bcd_time_t       time_q, time_d, time_inc;
    logic            min_event_q, min_event_d;
    bcd_hm_t         load_hm;
    logic            load_ok, ld_time_ok, ld_alarm_ok, sec_tick;

    assign load_hm.h1  = H_in1;
    assign load_hm.h0  = H_in0;
    assign load_hm.m1  = M_in1;
    assign load_hm.m0  = M_in0;
    assign load_ok     = bcd_hm_valid(load_hm);
    assign ld_time_ok  = LD_time && load_ok;
    assign ld_alarm_ok = LD_alarm && load_ok;
    assign sec_tick    = (ps_q == PS_LAST);

    always_comb begin
        time_inc = time_q;
        if (time_q.s0 != 4'd9) begin
            time_inc.s0 = time_q.s0 + 4'd1;
        end else begin
            time_inc.s0 = 4'd0;
            if (time_q.s1 != 4'd5) begin
                time_inc.s1 = time_q.s1 + 4'd1;
            end else begin
                time_inc.s1 = 4'd0;
                if (time_q.hm.m0 != 4'd9) begin
                    time_inc.hm.m0 = time_q.hm.m0 + 4'd1;
                end else begin
                    time_inc.hm.m0 = 4'd0;
                    if (time_q.hm.m1 != 4'd5) begin
                        time_inc.hm.m1 = time_q.hm.m1 + 4'd1;
                    end else begin
                        time_inc.hm.m1 = 4'd0;
                        if ((time_q.hm.h1 == 2'd2) && (time_q.hm.h0 == 4'd3)) begin
                            time_inc.hm.h1 = 2'd0;
                            time_inc.hm.h0 = 4'd0;
                        end else if (time_q.hm.h0 == 4'd9) begin
                            time_inc.hm.h0 = 4'd0;
                            time_inc.hm.h1 = time_q.hm.h1 + 2'd1;
                        end else begin
                            time_inc.hm.h0 = time_q.hm.h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // A time load wins over a coincident tick and never raises min_event.
    always_comb begin
        ps_d        = ps_q;
        time_d      = time_q;
        min_event_d = 1'b0;
        if (ld_time_ok) begin
            time_d.hm = load_hm;
            time_d.s1 = 4'd0;
            time_d.s0 = 4'd0;
            ps_d      = '0;
        end else if (sec_tick) begin
            time_d      = time_inc;
            ps_d        = '0;
            min_event_d = (time_inc.s1 == 4'd0) && (time_inc.s0 == 4'd0);
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_q        <= '0;
            time_q      <= '0;
            min_event_q <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            time_q      <= time_d;
            min_event_q <= min_event_d;
        end
    end

    // Out-of-range selects match no generated index and are dropped.
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_chan
        logic ld_this;
        assign ld_this = ld_alarm_ok && (alarm_sel == SEL_W'(gi));

        alarm_channel #(
            .SNOOZE_MIN  (SNOOZE_MIN),
            .TIMEOUT_MIN (TIMEOUT_MIN)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .al_on     (AL_ON[gi]),
            .ld_alarm  (ld_this),
            .ld_hm     (load_hm),
            .cur_hm    (time_q.hm),
            .min_event (min_event_q),
            .stop_al   (STOP_al),
            .snooze    (SNOOZE),
            .ringing   (ringing[gi])
        );
    end

    assign Alarm  = |ringing;
    assign H_out1 = time_q.hm.h1;
    assign H_out0 = time_q.hm.h0;
    assign M_out1 = time_q.hm.m1;
    assign M_out0 = time_q.hm.m0;
    assign S_out1 = time_q.s1;
    assign S_out0 = time_q.s0;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: directed scenarios plus a
// randomized run, all compared against a seconds/minutes-of-day model.
module tb_multi_alarm_clock;

    localparam int CLK_HZ = 2;
    // Non power-of-two so out-of-range selects are representable.
    localparam int NA     = 5;
    localparam int SNZ    = 5;
    localparam int TMO    = 10;
    localparam int SW     = $clog2(NA);
    localparam int S_IDLE = 0;
    localparam int S_RING = 1;
    localparam int S_SNZ  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    H_in1 = '0;
    logic [3:0]    H_in0 = '0, M_in1 = '0, M_in0 = '0;
    logic          LD_time = 1'b0, LD_alarm = 1'b0;
    logic [SW-1:0] alarm_sel = '0;
    logic [NA-1:0] AL_ON = '0;
    logic          STOP_al = 1'b0, SNOOZE = 1'b0;
    logic          Alarm;
    logic [NA-1:0] ringing;
    logic [1:0]    H_out1;
    logic [3:0]    H_out0, M_out1, M_out0, S_out1, S_out0;

    logic [21:0]    dut_time;
    logic [NA+22:0] dut_outs;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_alarm_clock #(
        .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .TIMEOUT_MIN(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .alarm_sel(alarm_sel),
        .AL_ON(AL_ON), .STOP_al(STOP_al), .SNOOZE(SNOOZE),
        .Alarm(Alarm), .ringing(ringing),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0)
    );

    assign dut_time = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    assign dut_outs = {ringing, Alarm, dut_time};

    // ---------------- reference model ----------------
    int m_sec, m_cnt;
    bit m_me;
    int m_al[NA], m_st[NA], m_tgt[NA], m_tmo[NA];

    function automatic logic [21:0] bcd22(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [NA+22:0] model_outs();
        logic [NA-1:0] r;
        for (int i = 0; i < NA; i++) r[i] = (m_st[i] == S_RING);
        return {r, |r, bcd22(m_sec / 3600, (m_sec / 60) % 60, m_sec % 60)};
    endfunction

    task automatic model_reset();
        m_sec = 0; m_cnt = 0; m_me = 0;
        for (int i = 0; i < NA; i++) begin
            m_al[i] = 0; m_st[i] = S_IDLE; m_tgt[i] = 0; m_tmo[i] = 0;
        end
    endtask

    task automatic model_clock();
        int hh, mm, cur_min, ld_min;
        bit in_ok, ld_sel;
        if (!reset_n) begin
            model_reset();
            return;
        end
        hh      = int'(H_in1) * 10 + int'(H_in0);
        mm      = int'(M_in1) * 10 + int'(M_in0);
        in_ok   = (hh <= 23) && (H_in0 <= 9) && (M_in1 <= 5) && (M_in0 <= 9);
        ld_min  = hh * 60 + mm;
        cur_min = m_sec / 60;
        for (int i = 0; i < NA; i++) begin
            ld_sel = LD_alarm && in_ok && (int'(alarm_sel) == i);
            if (!AL_ON[i] || ld_sel) begin
                m_st[i] = S_IDLE;
            end else if (m_st[i] == S_IDLE) begin
                if (m_me && !STOP_al && cur_min == m_al[i]) begin
                    m_st[i] = S_RING; m_tmo[i] = 0;
                end
            end else if (m_st[i] == S_RING) begin
                if (STOP_al) m_st[i] = S_IDLE;
                else if (SNOOZE) begin
                    m_st[i] = S_SNZ; m_tgt[i] = (cur_min + SNZ) % 1440;
                end else if (m_me) begin
                    m_tmo[i]++;
                    if (m_tmo[i] == TMO) m_st[i] = S_IDLE;
                end
            end else begin
                if (STOP_al) m_st[i] = S_IDLE;
                else if (m_me && cur_min == m_tgt[i]) begin
                    m_st[i] = S_RING; m_tmo[i] = 0;
                end
            end
            if (ld_sel) m_al[i] = ld_min;
        end
        if (LD_time && in_ok) begin
            m_sec = ld_min * 60; m_cnt = 0; m_me = 0;
        end else if (m_cnt == CLK_HZ - 1) begin
            m_sec = (m_sec + 1) % 86400; m_cnt = 0; m_me = (m_sec % 60 == 0);
        end else begin
            m_cnt++; m_me = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_clock();
            #1;
        end
    endtask

    task automatic set_hm(input int h, input int m);
        H_in1 = 2'(h / 10); H_in0 = 4'(h % 10);
        M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
    endtask

    task automatic load_time(input int h, input int m);
        set_hm(h, m); LD_time = 1'b1; cyc(1); LD_time = 1'b0;
    endtask

    task automatic load_alarm(input int sel, input int h, input int m);
        set_hm(h, m); alarm_sel = SW'(sel); LD_alarm = 1'b1; cyc(1); LD_alarm = 1'b0;
    endtask

    task automatic run_until(input int target_sec, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cyc(1);
            if (m_sec == target_sec) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; LD_time = 0; LD_alarm = 0; STOP_al = 0; SNOOZE = 0; AL_ON = '0;
        #1;
        model_reset();
        cyc(2);
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if (dut_outs !== '0) begin
            $display("FAIL reset_state got=%h exp=0", dut_outs); bad++;
        end
        load_time(12, 34);
        cyc(5);
        total++;
        if (dut_time !== bcd22(12, 34, 2) || dut_outs !== model_outs()) begin
            $display("FAIL pre_reset_time got=%h exp=%h", dut_outs, model_outs()); bad++;
        end
        reset_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (dut_outs !== '0) begin
            $display("FAIL async_reset got=%h exp=0", dut_outs); bad++;
        end
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        total++;
        if (dut_time !== bcd22(0, 0, 1) || dut_outs !== model_outs()) begin
            $display("FAIL post_reset_count got=%h exp=%h", dut_time, bcd22(0, 0, 1)); bad++;
        end
        $display("test_reset done");
    endtask

    task automatic test_rollover();
        bit saw_carry = 1'b0;
        logic [7:0] prev_s;
        load_time(23, 59);
        total++;
        if (dut_time !== bcd22(23, 59, 0)) begin
            $display("FAIL ld_time got=%h exp=%h", dut_time, bcd22(23, 59, 0)); bad++;
        end
        for (int k = 0; k < 120; k++) begin
            prev_s = {S_out1, S_out0};
            cyc(1);
            if (prev_s == 8'h59 && {S_out1, S_out0} == 8'h00) saw_carry = 1'b1;
            total++;
            if (dut_outs !== model_outs()) begin
                $display("FAIL rollover_cyc%0d got=%h exp=%h", k, dut_outs, model_outs()); bad++;
            end
        end
        total++;
        if (dut_time !== bcd22(0, 0, 0) || !saw_carry) begin
            $display("FAIL midnight got=%h carry=%0d exp=%h carry=1", dut_time, saw_carry, bcd22(0, 0, 0));
            bad++;
        end
        $display("test_rollover done");
    endtask

    task automatic test_alarm_basic();
        bit ok;
        do_reset();
        AL_ON = 5'b00100;
        load_alarm(2, 0, 1);
        load_time(0, 0);
        run_until(60, 200, ok);
        total++;
        if (!ok || ringing !== '0 || dut_time !== bcd22(0, 1, 0)) begin
            $display("FAIL basic_at_display ok=%0d ringing=%b time=%h exp ringing=0", ok, ringing, dut_time);
            bad++;
        end
        cyc(1);
        total++;
        if (ringing !== 5'b00100 || Alarm !== 1'b1) begin
            $display("FAIL basic_ring got=%b/%b exp=00100/1", ringing, Alarm); bad++;
        end
        STOP_al = 1'b1; cyc(1); STOP_al = 1'b0;
        total++;
        if (ringing !== '0 || Alarm !== 1'b0 || dut_outs !== model_outs()) begin
            $display("FAIL basic_stop got=%b/%b exp=0/0", ringing, Alarm); bad++;
        end
        $display("test_alarm_basic done");
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        AL_ON = 5'b00100;
        load_alarm(2, 0, 1);
        load_time(0, 0);
        run_until(60, 200, ok);
        cyc(1);
        run_until(11 * 60, 1400, ok);
        total++;
        if (!ok || Alarm !== 1'b1) begin
            $display("FAIL timeout_before ok=%0d Alarm=%b exp=1", ok, Alarm); bad++;
        end
        cyc(1);
        total++;
        if (Alarm !== 1'b0 || dut_outs !== model_outs()) begin
            $display("FAIL timeout_drop Alarm=%b exp=0", Alarm); bad++;
        end
        $display("test_timeout done");
    endtask

    task automatic test_snooze();
        bit ok;
        do_reset();
        AL_ON = 5'b00100;
        load_alarm(2, 23, 58);
        load_time(23, 57);
        run_until(86280, 200, ok);
        cyc(1);
        total++;
        if (!ok || Alarm !== 1'b1) begin
            $display("FAIL snooze_first_ring ok=%0d Alarm=%b exp=1", ok, Alarm); bad++;
        end
        for (int rep = 0; rep < 2; rep++) begin
            SNOOZE = 1'b1; cyc(1); SNOOZE = 1'b0;
            total++;
            if (Alarm !== 1'b0) begin
                $display("FAIL snooze%0d_quiet Alarm=%b exp=0", rep, Alarm); bad++;
            end
            run_until((3 + 5 * rep) * 60, 800, ok);
            total++;
            if (!ok || Alarm !== 1'b0) begin
                $display("FAIL snooze%0d_before ok=%0d Alarm=%b exp=0", rep, ok, Alarm); bad++;
            end
            cyc(1);
            total++;
            if (ringing !== 5'b00100 || Alarm !== 1'b1) begin
                $display("FAIL snooze%0d_rering got=%b exp=00100", rep, ringing); bad++;
            end
        end
        STOP_al = 1'b1; cyc(1); STOP_al = 1'b0;
        $display("test_snooze done");
    endtask

    task automatic test_invalid();
        bit ok;
        do_reset();
        AL_ON = 5'b00100;
        load_alarm(2, 0, 5);
        load_time(0, 4);
        H_in1 = 2'd2; H_in0 = 4'd4; M_in1 = 4'd0; M_in0 = 4'd0;
        LD_time = 1'b1; cyc(1); LD_time = 1'b0;
        total++;
        if (dut_time !== bcd22(0, 4, 0) || dut_outs !== model_outs()) begin
            $display("FAIL bad_ld_time got=%h exp=%h", dut_time, bcd22(0, 4, 0)); bad++;
        end
        H_in1 = 2'd0; H_in0 = 4'd0; M_in1 = 4'd6; M_in0 = 4'd0;
        alarm_sel = SW'(2); LD_alarm = 1'b1; cyc(1); LD_alarm = 1'b0;
        run_until(300, 300, ok);
        cyc(1);
        total++;
        if (!ok || ringing !== 5'b00100) begin
            $display("FAIL bad_ld_alarm ok=%0d ringing=%b exp=00100", ok, ringing); bad++;
        end
        SNOOZE = 1'b1; cyc(1); SNOOZE = 1'b0;
        AL_ON = '0; cyc(1); AL_ON = 5'b00100;
        run_until(600, 800, ok);
        cyc(2);
        total++;
        if (!ok || Alarm !== 1'b0 || dut_outs !== model_outs()) begin
            $display("FAIL alon_drop ok=%0d Alarm=%b exp=0", ok, Alarm); bad++;
        end
        $display("test_invalid done");
    endtask

    task automatic test_two_channels();
        bit ok;
        do_reset();
        AL_ON = '1;
        load_alarm(1, 0, 2);
        load_alarm(3, 0, 2);
        load_alarm(5, 0, 3);
        load_time(0, 1);
        run_until(120, 200, ok);
        cyc(1);
        total++;
        if (!ok || ringing !== 5'b01010 || Alarm !== 1'b1) begin
            $display("FAIL two_ring got=%b exp=01010", ringing); bad++;
        end
        STOP_al = 1'b1; cyc(1); STOP_al = 1'b0;
        total++;
        if (ringing !== '0) begin
            $display("FAIL two_stop got=%b exp=00000", ringing); bad++;
        end
        run_until(180, 200, ok);
        cyc(1);
        total++;
        if (!ok || ringing !== '0 || dut_outs !== model_outs()) begin
            $display("FAIL sel_out_of_range got=%b exp=00000", ringing); bad++;
        end
        $display("test_two_channels done");
    endtask

    task automatic test_random();
        int tmin, shown;
        shown = 0;
        do_reset();
        AL_ON = '1;
        for (int k = 0; k < 4000; k++) begin
            LD_time  = ($urandom_range(0, 199) == 0);
            LD_alarm = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                H_in1 = 2'($urandom_range(0, 3));  H_in0 = 4'($urandom_range(0, 15));
                M_in1 = 4'($urandom_range(0, 15)); M_in0 = 4'($urandom_range(0, 15));
            end else begin
                tmin = (m_sec / 60 + int'($urandom_range(0, 3))) % 1440;
                set_hm(tmin / 60, tmin % 60);
            end
            alarm_sel = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) AL_ON = NA'($urandom);
            STOP_al = ($urandom_range(0, 149) == 0);
            SNOOZE  = ($urandom_range(0, 39) == 0);
            cyc(1);
            total++;
            if (dut_outs !== model_outs()) begin
                bad++;
                if (shown < 10) begin
                    $display("FAIL random_cyc%0d got=%h exp=%h", k, dut_outs, model_outs());
                    shown++;
                end
            end
        end
        LD_time = 0; LD_alarm = 0; STOP_al = 0; SNOOZE = 0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_alarm_basic();
        test_timeout();
        test_snooze();
        test_invalid();
        test_two_channels();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
